// File: rtl/bp_update_arbiter.sv
// bp_update_arbiter
//   Collects up to N resolved branches per cycle from EX and serialises them,
//   oldest first, onto the single BTB/BHT update port of the branch predictor.
//   Entries live in a circular FIFO of DEPTH slots. A cycle's lanes are taken
//   all-or-nothing; when they do not fit, EX is stalled and must hold them.
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   ex_branch_en[N]         lane carries a resolved branch/jump
//   ex_cond_en[N]           lane is a conditional branch
//   ex_taken[N]             lane outcome (meaningful only when conditional)
//   ex_pc, ex_target        per-lane PC / resolved target, lane i at [i*XLEN +: XLEN]
//   ex_stall                this cycle's lanes were not accepted
//   upd_valid/upd_ready     handshake for the head entry towards BP
//   upd_cond, upd_taken     head entry kind / outcome
//   upd_pc, upd_target      head entry PC / target
//   count                   occupied entries
//   stall_cycles            saturating count of cycles with ex_stall high
module bp_update_arbiter #(
   parameter int N     = 3,
   parameter int DEPTH = 8,
   parameter int XLEN  = 32
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [N-1:0]             ex_branch_en,
   input  logic [N-1:0]             ex_cond_en,
   input  logic [N-1:0]             ex_taken,
   input  logic [N*XLEN-1:0]        ex_pc,
   input  logic [N*XLEN-1:0]        ex_target,
   output logic                     ex_stall,
   output logic                     upd_valid,
   input  logic                     upd_ready,
   output logic                     upd_cond,
   output logic                     upd_taken,
   output logic [XLEN-1:0]          upd_pc,
   output logic [XLEN-1:0]          upd_target,
   output logic [$clog2(DEPTH):0]   count,
   output logic [15:0]              stall_cycles
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   function automatic logic [CNT_W-1:0] popcnt(input logic [N-1:0] v);
      logic [CNT_W-1:0] acc;
      acc = '0;
      for (int i = 0; i < N; i++) begin
         acc = acc + CNT_W'(v[i]);
      end
      return acc;
   endfunction

   logic [XLEN-1:0]  pc_mem    [DEPTH];
   logic [XLEN-1:0]  tgt_mem   [DEPTH];
   logic             cond_mem  [DEPTH];
   logic             taken_mem [DEPTH];

   logic [PTR_W-1:0] head_reg, head_next;
   logic [PTR_W-1:0] tail_reg, tail_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [15:0]      stall_reg, stall_next;

   logic [CNT_W-1:0] n_req;
   logic [CNT_W-1:0] free_slots;
   logic             accept;
   logic             fire;
   logic [PTR_W-1:0] wr_idx [N];

   assign n_req      = popcnt(ex_branch_en);
   // Free space is judged on the registered count only; a head leaving this
   // same cycle does not make room for this cycle's lanes.
   assign free_slots = CNT_W'(DEPTH) - count_reg;
   assign ex_stall   = (n_req > free_slots);
   assign accept     = !ex_stall;

   assign upd_valid  = (count_reg != '0);
   assign fire       = upd_valid && upd_ready;

   // Each valid lane lands at tail plus the number of valid lanes below it,
   // so invalid lanes leave no holes in the FIFO.
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_lane
         localparam logic [N-1:0] BELOW = N'((1 << gi) - 1);
         assign wr_idx[gi] = tail_reg + PTR_W'(popcnt(ex_branch_en & BELOW));
      end
   endgenerate

   // Entry storage needs no reset: an entry is only observable while it is
   // counted, and the outputs are masked to zero when the FIFO is empty.
   always_ff @(posedge clock) begin
      for (int i = 0; i < N; i++) begin
         if (accept && ex_branch_en[i]) begin
            pc_mem[wr_idx[i]]    <= ex_pc[i*XLEN +: XLEN];
            tgt_mem[wr_idx[i]]   <= ex_target[i*XLEN +: XLEN];
            cond_mem[wr_idx[i]]  <= ex_cond_en[i];
            taken_mem[wr_idx[i]] <= ex_cond_en[i] & ex_taken[i];
         end
      end
   end

   always_comb begin
      head_next  = head_reg + PTR_W'(fire);
      tail_next  = tail_reg;
      count_next = count_reg - CNT_W'(fire);
      stall_next = stall_reg;
      if (accept) begin
         // n_req <= DEPTH, truncation to PTR_W is the mod-DEPTH wrap.
         tail_next  = tail_reg + PTR_W'(n_req);
         count_next = count_reg + n_req - CNT_W'(fire);
      end
      if (ex_stall && (stall_reg != 16'hFFFF)) begin
         stall_next = stall_reg + 16'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
         stall_reg <= '0;
      end else begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
         stall_reg <= stall_next;
      end
   end

   assign upd_cond     = upd_valid ? cond_mem[head_reg]  : 1'b0;
   assign upd_taken    = upd_valid ? taken_mem[head_reg] : 1'b0;
   assign upd_pc       = upd_valid ? pc_mem[head_reg]    : '0;
   assign upd_target   = upd_valid ? tgt_mem[head_reg]   : '0;
   assign count        = count_reg;
   assign stall_cycles = stall_reg;

endmodule

// File: tb/tb_bp_update_arbiter.sv
// Directed testbench for bp_update_arbiter (N=3, DEPTH=8, XLEN=32).
module tb_bp_update_arbiter;

   localparam int N     = 3;
   localparam int DEPTH = 8;
   localparam int XLEN  = 32;

   logic              clock;
   logic              reset;
   logic [N-1:0]      ex_branch_en;
   logic [N-1:0]      ex_cond_en;
   logic [N-1:0]      ex_taken;
   logic [N*XLEN-1:0] ex_pc;
   logic [N*XLEN-1:0] ex_target;
   logic              ex_stall;
   logic              upd_valid;
   logic              upd_ready;
   logic              upd_cond;
   logic              upd_taken;
   logic [XLEN-1:0]   upd_pc;
   logic [XLEN-1:0]   upd_target;
   logic [3:0]        count;
   logic [15:0]       stall_cycles;

   int n_cmp = 0;
   int n_bad = 0;

   bp_update_arbiter #(.N(N), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clock       (clock),
      .reset       (reset),
      .ex_branch_en(ex_branch_en),
      .ex_cond_en  (ex_cond_en),
      .ex_taken    (ex_taken),
      .ex_pc       (ex_pc),
      .ex_target   (ex_target),
      .ex_stall    (ex_stall),
      .upd_valid   (upd_valid),
      .upd_ready   (upd_ready),
      .upd_cond    (upd_cond),
      .upd_taken   (upd_taken),
      .upd_pc      (upd_pc),
      .upd_target  (upd_target),
      .count       (count),
      .stall_cycles(stall_cycles)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one clock and land 1ns after the rising edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_lanes();
      ex_branch_en = '0;
      ex_cond_en   = '0;
      ex_taken     = '0;
      ex_pc        = '0;
      ex_target    = '0;
   endtask

   task automatic set_lane(input int i, input logic cond, input logic taken,
                           input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt);
      ex_branch_en[i]          = 1'b1;
      ex_cond_en[i]            = cond;
      ex_taken[i]              = taken;
      ex_pc[i*XLEN +: XLEN]     = pc;
      ex_target[i*XLEN +: XLEN] = tgt;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      upd_ready = 1'b0;
      clear_lanes();
      step();
      step();
      n_cmp++; if (upd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%0b exp=0", upd_valid); end
      n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", count); end
      n_cmp++; if (ex_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%0b exp=0", ex_stall); end
      n_cmp++; if (stall_cycles !== 16'd0) begin n_bad++; $display("FAIL reset_stall_cycles got=%0d exp=0", stall_cycles); end
      n_cmp++; if (upd_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc got=%h exp=0", upd_pc); end
      reset = 1'b0;
      step();
      $display("reset: released, count=%0d", count);
   endtask

   task automatic test_two_lanes();
      upd_ready = 1'b1;
      clear_lanes();
      set_lane(0, 1'b1, 1'b1, 32'h4, 32'h18);
      set_lane(2, 1'b0, 1'b1, 32'hC, 32'h40);   // jal: taken bit must be dropped
      #1;
      n_cmp++; if (ex_stall !== 1'b0) begin n_bad++; $display("FAIL two_stall got=%0b exp=0", ex_stall); end
      step();
      clear_lanes();
      #1;
      n_cmp++; if (count !== 4'd2) begin n_bad++; $display("FAIL two_count got=%0d exp=2", count); end
      n_cmp++; if (upd_valid !== 1'b1) begin n_bad++; $display("FAIL two_v1 got=%0b exp=1", upd_valid); end
      n_cmp++; if (upd_pc !== 32'h4) begin n_bad++; $display("FAIL two_pc1 got=%h exp=4", upd_pc); end
      n_cmp++; if (upd_target !== 32'h18) begin n_bad++; $display("FAIL two_tgt1 got=%h exp=18", upd_target); end
      n_cmp++; if (upd_cond !== 1'b1 || upd_taken !== 1'b1) begin n_bad++; $display("FAIL two_ct1 got=%0b%0b exp=11", upd_cond, upd_taken); end
      $display("two_lanes: update pc=%h tgt=%h cond=%0b taken=%0b", upd_pc, upd_target, upd_cond, upd_taken);
      step();
      n_cmp++; if (upd_pc !== 32'hC) begin n_bad++; $display("FAIL two_pc2 got=%h exp=c", upd_pc); end
      n_cmp++; if (upd_target !== 32'h40) begin n_bad++; $display("FAIL two_tgt2 got=%h exp=40", upd_target); end
      n_cmp++; if (upd_cond !== 1'b0 || upd_taken !== 1'b0) begin n_bad++; $display("FAIL two_ct2 got=%0b%0b exp=00", upd_cond, upd_taken); end
      $display("two_lanes: update pc=%h tgt=%h cond=%0b taken=%0b", upd_pc, upd_target, upd_cond, upd_taken);
      step();
      n_cmp++; if (upd_valid !== 1'b0) begin n_bad++; $display("FAIL two_v3 got=%0b exp=0", upd_valid); end
      n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL two_count3 got=%0d exp=0", count); end
   endtask

   task automatic test_backpressure();
      upd_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         clear_lanes();
         for (int l = 0; l < 3; l++) set_lane(l, 1'b1, 1'(l), 32'h200 + 32'(12*c + 4*l), 32'h1000);
         step();
         $display("backpressure: enqueued 3, count=%0d", count);
      end
      n_cmp++; if (count !== 4'd6) begin n_bad++; $display("FAIL bp_count6 got=%0d exp=6", count); end
      clear_lanes();
      for (int l = 0; l < 3; l++) set_lane(l, 1'b0, 1'b0, 32'h900 + 32'(4*l), 32'h2000);
      #1;
      n_cmp++; if (ex_stall !== 1'b1) begin n_bad++; $display("FAIL bp_stall got=%0b exp=1", ex_stall); end
      step();
      n_cmp++; if (count !== 4'd6) begin n_bad++; $display("FAIL bp_count_hold got=%0d exp=6", count); end
      n_cmp++; if (stall_cycles !== 16'd1) begin n_bad++; $display("FAIL bp_stall_cycles got=%0d exp=1", stall_cycles); end
      clear_lanes();
      set_lane(0, 1'b0, 1'b0, 32'h218, 32'h1000);
      set_lane(1, 1'b0, 1'b0, 32'h21C, 32'h1000);
      #1;
      n_cmp++; if (ex_stall !== 1'b0) begin n_bad++; $display("FAIL bp_stall2 got=%0b exp=0", ex_stall); end
      step();
      n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL bp_count8 got=%0d exp=8", count); end
      $display("backpressure: 2 lanes accepted, count=%0d", count);
   endtask

   task automatic test_full();
      logic [XLEN-1:0] exp_pc;
      upd_ready = 1'b1;
      clear_lanes();
      set_lane(1, 1'b0, 1'b0, 32'h220, 32'h1000);
      #1;
      n_cmp++; if (ex_stall !== 1'b1) begin n_bad++; $display("FAIL full_stall got=%0b exp=1", ex_stall); end
      n_cmp++; if (upd_pc !== 32'h200) begin n_bad++; $display("FAIL full_head got=%h exp=200", upd_pc); end
      step();
      n_cmp++; if (count !== 4'd7) begin n_bad++; $display("FAIL full_count7 got=%0d exp=7", count); end
      n_cmp++; if (stall_cycles !== 16'd2) begin n_bad++; $display("FAIL full_stall_cycles got=%0d exp=2", stall_cycles); end
      upd_ready = 1'b0;
      #1;
      n_cmp++; if (ex_stall !== 1'b0) begin n_bad++; $display("FAIL full_stall2 got=%0b exp=0", ex_stall); end
      step();
      n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL full_count8 got=%0d exp=8", count); end
      clear_lanes();
      upd_ready = 1'b1;
      // Expected drain order: 204..21C then 220; stalled 'h9xx lanes never appear.
      for (int k = 0; k < 8; k++) begin
         exp_pc = 32'h204 + 32'(4*k);
         #1;
         n_cmp++; if (upd_valid !== 1'b1 || upd_pc !== exp_pc) begin
            n_bad++; $display("FAIL full_drain%0d got=%0b/%h exp=1/%h", k, upd_valid, upd_pc, exp_pc);
         end
         $display("full: drain pc=%h", upd_pc);
         step();
      end
      n_cmp++; if (count !== 4'd0 || upd_valid !== 1'b0) begin n_bad++; $display("FAIL full_empty got=%0d/%0b exp=0/0", count, upd_valid); end
   endtask

   task automatic test_wrap();
      int mcount = 0;
      int enq_i  = 0;
      int exp_i  = 0;
      int cyc    = 0;
      logic exp_stall;
      logic rdy;
      logic did_fire;
      while (exp_i < 20 && cyc < 200) begin
         rdy = (cyc % 2 == 0);
         upd_ready = rdy;
         clear_lanes();
         if (enq_i < 20) set_lane(0, 1'b0, 1'b0, 32'h100 + 32'(4*enq_i), 32'h3000);
         #1;
         exp_stall = (enq_i < 20) && (mcount == DEPTH);
         n_cmp++; if (ex_stall !== exp_stall) begin n_bad++; $display("FAIL wrap_stall c%0d got=%0b exp=%0b", cyc, ex_stall, exp_stall); end
         n_cmp++; if (upd_valid !== (mcount != 0)) begin n_bad++; $display("FAIL wrap_valid c%0d got=%0b exp=%0b", cyc, upd_valid, mcount != 0); end
         did_fire = (mcount != 0) && rdy;
         if (did_fire) begin
            n_cmp++; if (upd_pc !== 32'h100 + 32'(4*exp_i)) begin
               n_bad++; $display("FAIL wrap_pc%0d got=%h exp=%h", exp_i, upd_pc, 32'h100 + 32'(4*exp_i));
            end
            $display("wrap: dequeue #%0d pc=%h", exp_i, upd_pc);
            exp_i++;
         end
         if (enq_i < 20 && !exp_stall) begin
            mcount++;
            enq_i++;
         end
         if (did_fire) mcount--;
         step();
         cyc++;
      end
      n_cmp++; if (exp_i != 20) begin n_bad++; $display("FAIL wrap_timeout got=%0d exp=20", exp_i); end
      n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL wrap_count got=%0d exp=0", count); end
      clear_lanes();
   endtask

   task automatic test_reset_mid();
      upd_ready = 1'b0;
      clear_lanes();
      for (int l = 0; l < 3; l++) set_lane(l, 1'b1, 1'b1, 32'h700 + 32'(4*l), 32'h4000);
      step();
      clear_lanes();
      for (int l = 0; l < 2; l++) set_lane(l, 1'b1, 1'b1, 32'h70C + 32'(4*l), 32'h4000);
      step();
      clear_lanes();
      n_cmp++; if (count !== 4'd5 || upd_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre got=%0d/%0b exp=5/1", count, upd_valid); end
      #2;
      reset = 1'b1;
      #1;
      n_cmp++; if (upd_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid got=%0b exp=0", upd_valid); end
      n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL mid_count got=%0d exp=0", count); end
      step();
      reset = 1'b0;
      upd_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         n_cmp++; if (upd_valid !== 1'b0) begin n_bad++; $display("FAIL mid_ghost%0d got=%0b/%h exp=0", k, upd_valid, upd_pc); end
      end
      set_lane(1, 1'b0, 1'b0, 32'h800, 32'h5000);
      step();
      clear_lanes();
      #1;
      n_cmp++; if (upd_valid !== 1'b1 || upd_pc !== 32'h800) begin n_bad++; $display("FAIL mid_new got=%0b/%h exp=1/800", upd_valid, upd_pc); end
      $display("reset_mid: first update after reset pc=%h", upd_pc);
      step();
   endtask

   initial begin
      test_reset();
      test_two_lanes();
      test_backpressure();
      test_full();
      test_wrap();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
